gpio_in_filter: RTL and testbench

// - Per-pin input conditioning between the GPIO pad p2c outputs and the SoC gpio_i bus.
// - Each pin is synchronised into clk_i and debounced with a runtime threshold.
// - Each pin produces a single-cycle rise and fall pulse and a sticky, maskable pending bit.
// - irq_o is the OR of all pending bits and feeds the SoC interrupt input.

---
 rtl/gpio_in_filter_pkg.sv | 15 +
 rtl/gpio_filter_chan.sv | 100 ++++++++++
 rtl/gpio_in_filter.sv | 58 +++++
 tb/tb_gpio_in_filter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_in_filter_pkg.sv
// Shared constants and types for the GPIO input filter.
package gpio_in_filter_pkg;

  // Default pin count, matching the SoC GPIO bus width.
  localparam int unsigned GpioFiltCount = 30;

  // Default synchroniser depth (two flops minimum for metastability settling).
  localparam int unsigned GpioFiltSyncStages = 2;

  // Debounce counter width; the largest usable threshold is 2^width-1.
  localparam int unsigned GpioFiltCntWidth = 8;

  typedef logic [GpioFiltCntWidth-1:0] gpio_filt_cnt_t;

endpackage

// File: rtl/gpio_filter_chan.sv
// One GPIO pin: synchroniser, debounce counter, filtered level, edge pulses
// and the sticky pending flag.
module gpio_filter_chan
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned SyncStages = GpioFiltSyncStages,
  parameter int unsigned CntWidth   = GpioFiltCntWidth
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                pad_i,
  input  logic [CntWidth-1:0] thresh_i,
  input  logic                rise_en_i,
  input  logic                fall_en_i,
  input  logic                clear_i,
  output logic                level_o,
  output logic                rise_o,
  output logic                fall_o,
  output logic                pending_o
);

  // The synchroniser chain must survive synthesis untouched so the
  // metastability settling time is preserved.
  (* dont_touch = "true" *) logic [SyncStages-1:0] sync_q;

  logic                sync_bit;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                level_q, level_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic                pending_q, pending_d;

  logic                diff;
  logic [CntWidth:0]   cnt_inc;
  logic                reached;

  assign sync_bit = sync_q[SyncStages-1];

  // Shift the raw pad value through the synchroniser, nothing else in the chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], pad_i};
    end
  end

  // The increment and compare are one bit wider than the counter so that
  // cnt+1 never wraps and an all-ones threshold is still reachable.
  assign diff    = (sync_bit != level_q);
  assign cnt_inc = {1'b0, cnt_q} + {{CntWidth{1'b0}}, 1'b1};
  assign reached = (cnt_inc >= {1'b0, thresh_i});

  // Debounce: accept the synced value once it has disagreed long enough;
  // thresholds of 0 and 1 both accept on the first disagreeing edge.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!diff) begin
      cnt_d = '0;
    end else if (reached) begin
      level_d = sync_bit;
      cnt_d   = '0;
      rise_d  = sync_bit;
      fall_d  = ~sync_bit;
    end else if (cnt_q != {CntWidth{1'b1}}) begin
      cnt_d = cnt_inc[CntWidth-1:0];
    end
  end

  // Pending is set by an enabled pulse of the current cycle; set beats clear.
  always_comb begin
    pending_d = (rise_q & rise_en_i) | (fall_q & fall_en_i) | (pending_q & ~clear_i);
  end

  // State and registered outputs; pulses share the cycle of the new level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      level_q   <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
    end
  end

  assign level_o   = level_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: one filter channel per pin plus the interrupt
// request built from all pending flags.
module gpio_in_filter
  import gpio_in_filter_pkg::*;
#(
  parameter int unsigned GpioCount  = GpioFiltCount,
  parameter int unsigned SyncStages = GpioFiltSyncStages,
  parameter int unsigned CntWidth   = GpioFiltCntWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [GpioCount-1:0] pad_gpio_i,
  input  logic [CntWidth-1:0]  thresh_i,
  input  logic [GpioCount-1:0] rise_en_i,
  input  logic [GpioCount-1:0] fall_en_i,
  input  logic [GpioCount-1:0] clear_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] rise_o,
  output logic [GpioCount-1:0] fall_o,
  output logic [GpioCount-1:0] pending_o,
  output logic                 irq_o
);

  logic irq_q, irq_d;

  for (genvar gi = 0; gi < GpioCount; gi++) begin : g_chan
    gpio_filter_chan #(
      .SyncStages (SyncStages),
      .CntWidth   (CntWidth)
    ) u_chan (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pad_i      (pad_gpio_i[gi]),
      .thresh_i   (thresh_i),
      .rise_en_i  (rise_en_i[gi]),
      .fall_en_i  (fall_en_i[gi]),
      .clear_i    (clear_i[gi]),
      .level_o    (gpio_o[gi]),
      .rise_o     (rise_o[gi]),
      .fall_o     (fall_o[gi]),
      .pending_o  (pending_o[gi])
    );
  end

  assign irq_d = |pending_o;

  // Register the interrupt so it leaves the block from a flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed scenarios followed by a randomized run, all checked against a
// cycle-level behavioural model of the pin filter.
module tb_gpio_in_filter;
  import gpio_in_filter_pkg::*;

  localparam int N = 30;
  localparam int S = 2;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   pad, rise_en, fall_en, clear;
  gpio_filt_cnt_t thresh;
  logic [N-1:0]   gpio_o, rise_o, fall_o, pending_o;
  logic           irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  // model state
  logic [N-1:0] m_lvl, m_rise, m_fall, m_pend;
  logic         m_irq;
  int           m_run[N];
  logic [N-1:0] m_hist[$];

  always #5 clk = ~clk;

  gpio_in_filter #(.GpioCount(N), .SyncStages(S), .CntWidth(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .pad_gpio_i (pad),
    .thresh_i   (thresh),
    .rise_en_i  (rise_en),
    .fall_en_i  (fall_en),
    .clear_i    (clear),
    .gpio_o     (gpio_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .pending_o  (pending_o),
    .irq_o      (irq_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lvl = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_irq = 1'b0;
    foreach (m_run[i]) m_run[i] = 0;
    m_hist = {};
    for (int k = 0; k < S; k++) m_hist.push_back('0);
  endtask

  // Pad value seen by the debouncer is the one sampled S edges earlier;
  // m_run counts consecutive edges on which that value disagreed with the level.
  task automatic model_edge();
    logic [N-1:0] used, nlvl, nrise, nfall, npend;
    int th;
    used  = m_hist[S-1];
    th    = int'(thresh);
    nlvl  = m_lvl;
    nrise = '0;
    nfall = '0;
    for (int i = 0; i < N; i++) begin
      if (used[i] == m_lvl[i]) begin
        m_run[i] = 0;
      end else if (m_run[i] + 1 >= th) begin
        nlvl[i]  = used[i];
        nrise[i] = used[i];
        nfall[i] = ~used[i];
        m_run[i] = 0;
      end else if (m_run[i] < 255) begin
        m_run[i] = m_run[i] + 1;
      end
    end
    npend  = (m_rise & rise_en) | (m_fall & fall_en) | (m_pend & ~clear);
    m_irq  = |m_pend;
    m_pend = npend;
    m_lvl  = nlvl;
    m_rise = nrise;
    m_fall = nfall;
    m_hist.push_front(pad);
    void'(m_hist.pop_back());
  endtask

  task automatic check_all(input string tag);
    check({tag, "_gpio"}, gpio_o, m_lvl);
    check({tag, "_rise"}, rise_o, m_rise);
    check({tag, "_fall"}, fall_o, m_fall);
    check({tag, "_pend"}, pending_o, m_pend);
    check({tag, "_irq"}, irq_o, m_irq);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
    #1;
    check_all("cyc");
  endtask

  initial begin
    rst = 1'b1; pad = '0; thresh = '0; rise_en = '0; fall_en = '0; clear = '0;
    model_reset();
    #1;
    check("reset_gpio", gpio_o, 0);
    check("reset_rise", rise_o, 0);
    check("reset_fall", fall_o, 0);
    check("reset_pend", pending_o, 0);
    check("reset_irq", irq_o, 0);
    tick();
    rst = 1'b0;

    // Bypass: level follows after SyncStages+1 edges, one rise pulse.
    thresh = 0;
    pad[0] = 1'b1;
    tick(); check("byp_e1_gpio0", gpio_o[0], 0);
    tick(); check("byp_e2_gpio0", gpio_o[0], 0);
    tick(); check("byp_e3_gpio0", gpio_o[0], 1); check("byp_e3_rise0", rise_o[0], 1);
    tick(); check("byp_e4_rise0", rise_o[0], 0); check("byp_e4_gpio0", gpio_o[0], 1);
    pad[0] = 1'b0;
    repeat (5) tick();
    check("byp_fall_back", gpio_o[0], 0);

    // Debounce: 3-cycle glitch rejected, 4-cycle pulse accepted at edge 6.
    thresh = 4;
    pad[5] = 1'b1;
    repeat (3) tick();
    pad[5] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("glitch_gpio5", gpio_o[5], 0);
      check("glitch_rise5", rise_o[5], 0);
    end
    pad[5] = 1'b1;
    repeat (4) tick();
    pad[5] = 1'b0;
    tick(); check("deb_e5_gpio5", gpio_o[5], 0);
    tick(); check("deb_e6_gpio5", gpio_o[5], 1); check("deb_e6_rise5", rise_o[5], 1);
    repeat (10) tick();
    check("deb_settle_gpio5", gpio_o[5], 0);

    // Pending on rise only, irq one cycle later, cleared by clear pulse.
    thresh = 0;
    rise_en[7] = 1'b1;
    fall_en[7] = 1'b0;
    pad[7] = 1'b1;
    repeat (3) tick();
    check("pend_rise7", rise_o[7], 1);
    check("pend_pre7", pending_o[7], 0);
    tick(); check("pend_set7", pending_o[7], 1); check("pend_irq_lag", irq_o, 0);
    tick(); check("pend_irq", irq_o, 1);
    pad[7] = 1'b0;
    repeat (3) tick();
    check("pend_fall7", fall_o[7], 1);
    tick(); check("pend_hold7", pending_o[7], 1);
    clear[7] = 1'b1;
    tick(); check("pend_clr7", pending_o[7], 0); check("pend_clr_irq_lag", irq_o, 1);
    clear[7] = 1'b0;
    tick(); check("pend_clr_irq", irq_o, 0);

    // Set wins over a coincident clear.
    rise_en[2] = 1'b1;
    pad[2] = 1'b1;
    repeat (3) tick();
    check("coll_rise2", rise_o[2], 1);
    clear[2] = 1'b1;
    tick(); check("coll_pend2", pending_o[2], 1);
    clear = '1;
    tick();
    clear = '0;
    tick();
    check("coll_cleared", pending_o, 0);

    // Reset mid-count discards progress; the debounce restarts from zero.
    thresh = 10;
    pad[3] = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_gpio", gpio_o, 0);
    check("arst_pend", pending_o, 0);
    check_all("arst");
    tick(); tick();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 11) check("rst_restart_e11", gpio_o[3], 0);
      if (k == 12) check("rst_restart_e12", gpio_o[3], 1);
    end
    pad = '0;
    repeat (15) tick();

    // Threshold shrink mid-count takes effect at the next edge.
    thresh = 200;
    pad[1] = 1'b1;
    repeat (50) tick();
    check("shrink_pre_gpio1", gpio_o[1], 0);
    thresh = 20;
    tick();
    check("shrink_gpio1", gpio_o[1], 1);
    check("shrink_rise1", rise_o[1], 1);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      if (c % 400 == 0) thresh = gpio_filt_cnt_t'($urandom_range(0, 6));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) pad[i] = ~pad[i];
      rise_en = N'($urandom);
      fall_en = N'($urandom);
      clear   = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if (c == 1500) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rnd_arst");
      end
      if (c == 1503) rst = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
